// File: rtl/sic1_pkg.sv
// Shared SIC1 definitions: sequencer state encoding, special byte addresses, branch test.
// Build option SIC1_SINGLE_STEP_EN adds the S_PAUSE state used by single-step execution.
package sic1_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LD_A   = 3'd3,
    S_LD_B   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6
`ifdef SIC1_SINGLE_STEP_EN
    ,
    S_PAUSE  = 3'd7
`endif
  } state_t;

  localparam logic [7:0] ADDR_IN  = 8'd253;
  localparam logic [7:0] ADDR_OUT = 8'd254;
  localparam logic [7:0] ADDR_MAX = 8'd252;

  // SUBLEQ branches when the signed 8-bit result is zero or negative.
  function automatic logic branch_taken(input logic [7:0] res);
    return res[7] | (res == 8'd0);
  endfunction

endpackage

// File: rtl/sic1_sequencer_if.sv
// Sequencer <-> SIC1 byte memory bus: two word read ports, field breakout, byte write port.
// master = sequencer side, slave = memory side.
interface sic1_sequencer_if;

  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_byte;
  logic [5:0] mem_ra_addr;
  logic [5:0] mem_rb_addr;
  logic [1:0] mem_pc_low;
  logic [7:0] mem_out_A;
  logic [7:0] mem_out_B;
  logic [7:0] mem_out_C;
  logic [1:0] mem_rb_idx;
  logic [7:0] mem_rb_byte;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_byte,
    output mem_ra_addr, mem_rb_addr, mem_pc_low, mem_rb_idx,
    input  mem_out_A, mem_out_B, mem_out_C, mem_rb_byte
  );

  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_byte,
    input  mem_ra_addr, mem_rb_addr, mem_pc_low, mem_rb_idx,
    output mem_out_A, mem_out_B, mem_out_C, mem_rb_byte
  );

endinterface

// File: rtl/sic1_sequencer.sv
// SUBLEQ control FSM for the SIC1 byte memory: 5 cycles per instruction (FETCH..WRITE).
// Build option SIC1_SINGLE_STEP_EN: pause after each instruction until a step pulse.
module sic1_sequencer
  import sic1_pkg::state_t;
  import sic1_pkg::S_IDLE;
  import sic1_pkg::S_FETCH;
  import sic1_pkg::S_DECODE;
  import sic1_pkg::S_LD_A;
  import sic1_pkg::S_LD_B;
  import sic1_pkg::S_WRITE;
  import sic1_pkg::S_HALT;
`ifdef SIC1_SINGLE_STEP_EN
  import sic1_pkg::S_PAUSE;
`endif
  import sic1_pkg::branch_taken;
#(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter logic [7:0] ADDR_MAX = sic1_pkg::ADDR_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
`ifdef SIC1_SINGLE_STEP_EN
  input  logic                 step,
  output logic                 paused,
`endif
  output logic                 busy,
  output logic                 halted,
  output logic [7:0]           pc,
  sic1_sequencer_if.master     mem
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_a, w_a_nxt;
  logic [7:0] r_b, w_b_nxt;
  logic [7:0] r_c, w_c_nxt;
  logic [7:0] r_va, w_va_nxt;
  logic [7:0] r_vb, w_vb_nxt;
  logic [5:0] r_ra, w_ra_nxt;
  logic [5:0] r_rb, w_rb_nxt;

  logic [7:0] w_res;
  logic [7:0] w_npc;
  logic       w_npc_halts;

  assign w_res       = r_vb - r_va;
  assign w_npc       = branch_taken(w_res) ? r_c : r_pc + 8'd3;
  assign w_npc_halts = (w_npc > ADDR_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_c     <= 8'd0;
      r_va    <= 8'd0;
      r_vb    <= 8'd0;
      r_ra    <= 6'd0;
      r_rb    <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_c     <= w_c_nxt;
      r_va    <= w_va_nxt;
      r_vb    <= w_vb_nxt;
      r_ra    <= w_ra_nxt;
      r_rb    <= w_rb_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_c_nxt     = r_c;
    w_va_nxt    = r_va;
    w_vb_nxt    = r_vb;
    w_ra_nxt    = r_ra;
    w_rb_nxt    = r_rb;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_ra_nxt    = r_pc[7:2];
          w_rb_nxt    = r_pc[7:2] + 6'd1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_a_nxt     = mem.mem_out_A;
        w_b_nxt     = mem.mem_out_B;
        w_c_nxt     = mem.mem_out_C;
        w_rb_nxt    = mem.mem_out_A[7:2];
        w_state_nxt = S_LD_A;
      end
      S_LD_A: begin
        w_va_nxt    = mem.mem_rb_byte;
        w_ra_nxt    = r_b[7:2];
        w_rb_nxt    = r_b[7:2];
        w_state_nxt = S_LD_B;
      end
      S_LD_B: begin
        w_vb_nxt    = mem.mem_rb_byte;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        // ra is left on B's word through WRITE so the memory can merge the byte.
        w_pc_nxt = w_npc;
        if (w_npc_halts) begin
          w_state_nxt = S_HALT;
        end else begin
`ifdef SIC1_SINGLE_STEP_EN
          w_state_nxt = S_PAUSE;
`else
          w_ra_nxt    = w_npc[7:2];
          w_rb_nxt    = w_npc[7:2] + 6'd1;
          w_state_nxt = S_FETCH;
`endif
        end
      end
`ifdef SIC1_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          w_ra_nxt    = r_pc[7:2];
          w_rb_nxt    = r_pc[7:2] + 6'd1;
          w_state_nxt = S_FETCH;
        end
      end
`endif
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem.mem_rb_idx = 2'd0;
    case (r_state)
      S_LD_A:  mem.mem_rb_idx = r_a[1:0];
      S_LD_B:  mem.mem_rb_idx = r_b[1:0];
      default: mem.mem_rb_idx = 2'd0;
    endcase
  end

  assign mem.mem_wr_en   = (r_state == S_WRITE);
  assign mem.mem_wr_addr = r_b;
  assign mem.mem_wr_byte = w_res;
  assign mem.mem_ra_addr = r_ra;
  assign mem.mem_rb_addr = r_rb;
  assign mem.mem_pc_low  = r_pc[1:0];

  assign pc     = r_pc;
  assign halted = (r_state == S_HALT);
`ifdef SIC1_SINGLE_STEP_EN
  assign paused = (r_state == S_PAUSE);
  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_PAUSE);
`else
  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
`endif

endmodule

// File: tb/tb_sic1_sequencer.sv
// Directed bench for sic1_sequencer with a behavioural SIC1 byte memory (253 reads ui_in).
// Honours SIC1_SINGLE_STEP_EN by pulsing step whenever the sequencer pauses.
module tb_sic1_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       busy;
  logic       halted;
  logic [7:0] pc;
`ifdef SIC1_SINGLE_STEP_EN
  logic       step;
  logic       paused;
`endif

  sic1_sequencer_if u_if ();

  sic1_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
`ifdef SIC1_SINGLE_STEP_EN
    .step   (step),
    .paused (paused),
`endif
    .busy   (busy),
    .halted (halted),
    .pc     (pc),
    .mem    (u_if)
  );

  always #5 clk = ~clk;

  // Behavioural memory
  logic [7:0] ram  [256];
  logic [7:0] view [256];
  logic [7:0] ui_in;
  logic       tb_clr, tb_ld;
  logic [7:0] tb_addr, tb_dat;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (tb_ld) begin
      ram[tb_addr] <= tb_dat;
    end else if (u_if.mem_wr_en) begin
      ram[u_if.mem_wr_addr] <= u_if.mem_wr_byte;
    end
  end

  always_comb begin
    for (int i = 0; i < 256; i++) view[i] = (i == 253) ? ui_in : ram[i];
  end

  function automatic logic [7:0] fld_addr(input logic [5:0] ra, input logic [5:0] rb,
                                          input logic [2:0] k);
    return k[2] ? {rb, k[1:0]} : {ra, k[1:0]};
  endfunction

  assign u_if.mem_out_A   = view[fld_addr(u_if.mem_ra_addr, u_if.mem_rb_addr, {1'b0, u_if.mem_pc_low})];
  assign u_if.mem_out_B   = view[fld_addr(u_if.mem_ra_addr, u_if.mem_rb_addr, {1'b0, u_if.mem_pc_low} + 3'd1)];
  assign u_if.mem_out_C   = view[fld_addr(u_if.mem_ra_addr, u_if.mem_rb_addr, {1'b0, u_if.mem_pc_low} + 3'd2)];
  assign u_if.mem_rb_byte = view[{u_if.mem_rb_addr, u_if.mem_rb_idx}];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_ld = 1'b1; tb_addr = a; tb_dat = d;
    @(negedge clk);
    tb_ld = 1'b0;
  endtask

  task automatic mem_clear();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pc0;
    logic [7:0] a, b, c;
    logic [7:0] va, vb;
    logic [7:0] wr_byte;
    logic [7:0] npc;
    logic       halt;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, nwr, target, exp_cyc, late_wr;
    logic found;
    logic [7:0] got_addr, got_byte;
    rst = 1'b1; run = 1'b0; ui_in = v.va;
    mem_clear();
    // A self-cancelling hop (mem[200] - mem[200]) reaches a non-zero start PC.
    if (v.pc0 != 8'd0) begin
      poke(8'd0, 8'd200); poke(8'd1, 8'd200); poke(8'd2, v.pc0);
    end
    poke(v.pc0, v.a); poke(v.pc0 + 8'd1, v.b); poke(v.pc0 + 8'd2, v.c);
    poke(v.a, v.va);
    if (v.b != v.a) poke(v.b, v.vb);
    rst = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
    run = 1'b1;
    target = (v.pc0 == 8'd0) ? 1 : 2;
`ifdef SIC1_SINGLE_STEP_EN
    exp_cyc = (target == 1) ? 5 : 11;
`else
    exp_cyc = (target == 1) ? 5 : 10;
`endif
    found = 1'b0; cyc = 0; nwr = 0; got_addr = 8'd0; got_byte = 8'd0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      cyc++;
      run = 1'b0;
`ifdef SIC1_SINGLE_STEP_EN
      step = paused;
`endif
      if (u_if.mem_wr_en) begin
        nwr++;
        if (nwr == target) begin
          found = 1'b1; got_addr = u_if.mem_wr_addr; got_byte = u_if.mem_wr_byte;
        end
      end
    end
    check($sformatf("v%0d_write_seen", idx), {31'd0, found}, 32'd1);
    check($sformatf("v%0d_write_cycle", idx), cyc, exp_cyc);
    check($sformatf("v%0d_wr_addr", idx), {24'd0, got_addr}, {24'd0, v.b});
    check($sformatf("v%0d_wr_byte", idx), {24'd0, got_byte}, {24'd0, v.wr_byte});
    @(negedge clk);
    check($sformatf("v%0d_pc", idx), {24'd0, pc}, {24'd0, v.npc});
    check($sformatf("v%0d_halted", idx), {31'd0, halted}, {31'd0, v.halt});
    if (v.halt) begin
      late_wr = 0;
      repeat (8) begin
        @(negedge clk);
        if (u_if.mem_wr_en) late_wr++;
      end
      check($sformatf("v%0d_no_write_after_halt", idx), late_wr, 0);
      check($sformatf("v%0d_halt_busy", idx), {31'd0, busy}, 32'd0);
    end
  endtask

  int wr_cnt;

  initial begin
    rst = 1'b1; run = 1'b0; ui_in = 8'h00;
    tb_clr = 1'b0; tb_ld = 1'b0; tb_addr = 8'd0; tb_dat = 8'd0;
`ifdef SIC1_SINGLE_STEP_EN
    step = 1'b0;
`endif

    //          pc0     a       b       c       va     vb     byte   npc     halt
    vecs[0]  = '{8'd0,   8'd9,   8'd10,  8'd3,   8'h05, 8'h07, 8'h02, 8'd3,   1'b0};
    vecs[1]  = '{8'd0,   8'd9,   8'd10,  8'd3,   8'h07, 8'h05, 8'hFE, 8'd3,   1'b0};
    vecs[2]  = '{8'd0,   8'd9,   8'd10,  8'd100, 8'h05, 8'h07, 8'h02, 8'd3,   1'b0};
    vecs[3]  = '{8'd0,   8'd9,   8'd10,  8'd100, 8'h07, 8'h05, 8'hFE, 8'd100, 1'b0};
    vecs[4]  = '{8'd0,   8'd9,   8'd10,  8'd100, 8'h05, 8'h05, 8'h00, 8'd100, 1'b0};
    vecs[5]  = '{8'd6,   8'd20,  8'd20,  8'd40,  8'h33, 8'h33, 8'h00, 8'd40,  1'b0};
    vecs[6]  = '{8'd6,   8'd21,  8'd22,  8'd50,  8'h01, 8'h80, 8'h7F, 8'd9,   1'b0};
    vecs[7]  = '{8'd7,   8'd30,  8'd31,  8'd60,  8'h10, 8'h20, 8'h10, 8'd10,  1'b0};
    vecs[8]  = '{8'd0,   8'd253, 8'd254, 8'd255, 8'h41, 8'h41, 8'h00, 8'd255, 1'b1};
    vecs[9]  = '{8'd250, 8'd9,   8'd10,  8'd0,   8'h01, 8'h02, 8'h01, 8'd253, 1'b1};
    vecs[10] = '{8'd250, 8'd9,   8'd10,  8'd252, 8'h02, 8'h01, 8'hFF, 8'd252, 1'b0};
    vecs[11] = '{8'd0,   8'd9,   8'd10,  8'd40,  8'h80, 8'h00, 8'h80, 8'd40,  1'b0};

    // Reset / idle with run low
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (u_if.mem_wr_en) wr_cnt++;
    end
    check("rst_wr_en_never", wr_cnt, 0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_ra_addr", {26'd0, u_if.mem_ra_addr}, 32'd0);
    check("rst_rb_addr", {26'd0, u_if.mem_rb_addr}, 32'd0);
    check("rst_wr_addr", {24'd0, u_if.mem_wr_addr}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset landing in S_LD_B abandons the instruction
    rst = 1'b1; run = 1'b0; ui_in = 8'h00;
    mem_clear();
    poke(8'd0, 8'd9); poke(8'd1, 8'd10); poke(8'd2, 8'd3);
    poke(8'd9, 8'h05); poke(8'd10, 8'h07);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy_in_ld_b", {31'd0, busy}, 32'd1);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("mid_wr_en", {31'd0, u_if.mem_wr_en}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_pc", {24'd0, pc}, 32'd0);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (u_if.mem_wr_en) wr_cnt++;
    end
    check("mid_no_write", wr_cnt, 0);
    check("mid_mem10_kept", {24'd0, ram[10]}, 32'h07);

`ifdef SIC1_SINGLE_STEP_EN
    // One instruction per step; a step pulse while running is ignored
    rst = 1'b1; run = 1'b0;
    mem_clear();
    poke(8'd0, 8'd9);  poke(8'd1, 8'd10); poke(8'd2, 8'd3);
    poke(8'd3, 8'd11); poke(8'd4, 8'd12); poke(8'd5, 8'd6);
    poke(8'd9, 8'h05); poke(8'd10, 8'h07); poke(8'd11, 8'h01); poke(8'd12, 8'h04);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wr_cnt = 0;
    for (int k = 0; k < 20 && wr_cnt == 0; k++) begin
      @(negedge clk);
      run = 1'b0;
      if (u_if.mem_wr_en) wr_cnt++;
    end
    check("step_first_write", wr_cnt, 1);
    wr_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (u_if.mem_wr_en) wr_cnt++;
    end
    check("step_hold_no_write", wr_cnt, 0);
    check("step_paused", {31'd0, paused}, 32'd1);
    check("step_paused_busy", {31'd0, busy}, 32'd0);
    check("step_pc_before", {24'd0, pc}, 32'd3);
    step = 1'b1;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wr_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (u_if.mem_wr_en) wr_cnt++;
    end
    check("step_one_write", wr_cnt, 1);
    check("step_paused_again", {31'd0, paused}, 32'd1);
    check("step_pc_after", {24'd0, pc}, 32'd6);
    check("step_mem12", {24'd0, ram[12]}, 32'h03);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
